// File: rtl/button_event_arbiter_pkg.sv
// Shared types and constants for the button event arbiter and its key-code FIFO.
// The optional drop counter is controlled by the BTN_DROP_COUNT_EN macro in the top level.
package btn_pkg;

    localparam int N_BTN_MAX      = 16;
    localparam int DROP_CNT_W     = 8;
    localparam int KEY_CODE_MAX_W = $clog2(N_BTN_MAX);

    // Widest key code any supported configuration can produce.
    typedef logic [KEY_CODE_MAX_W-1:0] key_code_t;

    // Key-code width for n buttons; never narrower than one bit.
    function automatic int code_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_arbiter_key_fifo.sv
// Synchronous key-code FIFO: power-of-two depth, naturally wrapping pointers, separate count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module key_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // Head reads as zero while empty so downstream never sees stale codes.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that serialises button press pulses into a key-code FIFO.
// Define BTN_DROP_COUNT_EN to add the saturating drop_cnt output for merged presses.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CODE_W     = code_width(N_BTN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      press,
    input  logic                  arb_en,
    output logic                  key_valid,
    output logic [CODE_W-1:0]     key_code,
    input  logic                  key_ready,
    output logic                  fifo_full,
    output logic [CODE_W:0]       fifo_count,
`ifdef BTN_DROP_COUNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic [N_BTN-1:0]      dbg_pending,
    output logic [CODE_W-1:0]     dbg_rr_ptr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a key code transfers on every rising edge where key_valid and
    // key_ready are both high; key_valid never depends on key_ready, and the head
    // code holds steady until it is accepted.

    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              pop;
    logic              can_push;
    logic              grant_vld;
    logic [CODE_W-1:0] grant_idx;
    logic [N_BTN-1:0]  grant_oh;
    int                scan_idx;
    logic [CODE_W-1:0] scan_sel;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    // Round-robin search over registered pending bits, starting at rr_ptr.
    always_comb begin
        pop       = key_valid & key_ready;
        can_push  = arb_en & (~fifo_full | pop);
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_BTN) begin
                scan_idx = scan_idx - N_BTN;
            end
            scan_sel = CODE_W'(scan_idx);
            if (can_push && !grant_vld && pending_q[scan_sel]) begin
                grant_vld          = 1'b1;
                grant_idx          = scan_sel;
                grant_oh[scan_sel] = 1'b1;
            end
        end
    end

    // A press on a bit granted this cycle is a fresh event, so press is OR-ed in last.
    always_comb begin
        pending_d = (pending_q & ~grant_oh) | press;
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            if (int'(grant_idx) == N_BTN - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + CODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    key_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_vld),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign key_valid   = ~fifo_empty;
    assign fifo_count  = (CODE_W+1)'(fifo_cnt);
    assign dbg_pending = pending_q;
    assign dbg_rr_ptr  = rr_ptr_q;

`ifdef BTN_DROP_COUNT_EN
    localparam int DROP_MAX = (1 << DROP_CNT_W) - 1;

    logic [N_BTN-1:0]      merged;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    int                    drop_sum;

    // Several buttons can merge in one cycle; add them all, clamping at the top.
    always_comb begin
        merged     = press & pending_q & ~grant_oh;
        drop_sum   = int'(drop_cnt_q) + $countones(merged);
        drop_cnt_d = (drop_sum > DROP_MAX) ? DROP_CNT_W'(DROP_MAX) : DROP_CNT_W'(drop_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, latency, fill order, merges and arb_en hold.
module tb_button_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CODE_W     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_BTN-1:0]  press = '0;
  logic              arb_en = 1'b1;
  logic              key_ready = 1'b0;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              fifo_full;
  logic [CODE_W:0]   fifo_count;
  logic [N_BTN-1:0]  dbg_pending;
  logic [CODE_W-1:0] dbg_rr_ptr;
`ifdef BTN_DROP_COUNT_EN
  logic [7:0]        drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  button_event_arbiter #(
    .N_BTN      (N_BTN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .press       (press),
    .arb_en      (arb_en),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
`ifdef BTN_DROP_COUNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .dbg_pending (dbg_pending),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // reference model: pending set, rr pointer, code queue
  logic [CODE_W-1:0] exp_q[$];
  logic [N_BTN-1:0]  m_pend = '0;
  int                m_rr   = 0;
  int                m_drop = 0;

  always @(posedge clk) begin
    int  g;
    int  nd;
    int  idx;
    bit  m_pop;
    bit  m_can;
    if (reset) begin
      exp_q.delete();
      m_pend = '0;
      m_rr   = 0;
      m_drop = 0;
    end else begin
      m_pop = (exp_q.size() > 0) && key_ready;
      m_can = arb_en && ((exp_q.size() < FIFO_DEPTH) || m_pop);
      g = -1;
      if (m_can) begin
        for (int k = 0; k < N_BTN; k++) begin
          idx = (m_rr + k) % N_BTN;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      end
      nd = 0;
      for (int i = 0; i < N_BTN; i++) begin
        if (press[i] && m_pend[i] && i != g) nd++;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(CODE_W'(g));
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % N_BTN;
      end
      m_pend = m_pend | press;
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    end
    #1;
    check("cyc_key_valid", int'(key_valid), (exp_q.size() > 0) ? 1 : 0);
    check("cyc_key_code", int'(key_code), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
    check("cyc_fifo_count", int'(fifo_count), exp_q.size());
    check("cyc_fifo_full", int'(fifo_full), (exp_q.size() == FIFO_DEPTH) ? 1 : 0);
    check("cyc_pending", int'(dbg_pending), int'(m_pend));
`ifdef BTN_DROP_COUNT_EN
    check("cyc_drop_cnt", int'(drop_cnt), m_drop);
`endif
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp4[5] = '{0, 1, 2, 3, 0};
  int exp5[5] = '{3, 0, 1, 2, 1};
  logic [N_BTN-1:0] tbl_press[12] = '{4'b0001, 4'b1010, 4'b0000, 4'b1111, 4'b0110, 4'b0000,
                                      4'b1001, 4'b1111, 4'b0100, 4'b0000, 4'b0011, 4'b1000};
  logic             tbl_ready[12] = '{0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  logic             tbl_arb[12]   = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    @(negedge clk);
    ticks(2);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_pending", int'(dbg_pending), 0);
    reset = 1'b0;
    tick();

    // fill with all four buttons at once
    key_ready = 1'b0;
    press = 4'b1111;
    tick();
    press = '0;
    ticks(4);
    check("fill_full", int'(fifo_full), 1);
    check("fill_count", int'(fifo_count), 4);
    check("fill_head", int'(key_code), 0);
    check("fill_rr", int'(dbg_rr_ptr), 0);

    // press[0] while full, then drain
    press = 4'b0001;
    tick();
    press = '0;
    check("full_hold_pending", int'(dbg_pending), 1);
    key_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain4_valid", int'(key_valid), 1);
      check("drain4_code", int'(key_code), exp4[k]);
      tick();
      if (k == 0) check("pop_push_count", int'(fifo_count), 4);
    end
    check("drain4_empty", int'(key_valid), 0);
    check("drain4_empty_code", int'(key_code), 0);

    // single press latency
    press = 4'b0100;
    tick();
    press = '0;
    check("lat_not_yet", int'(key_valid), 0);
    tick();
    check("lat_valid", int'(key_valid), 1);
    check("lat_code", int'(key_code), 2);
    tick();
    check("lat_one_cycle", int'(key_valid), 0);

    // merges while full
    key_ready = 1'b0;
    press = 4'b1111;
    tick();
    press = '0;
    ticks(4);
    check("merge_full", int'(fifo_full), 1);
    for (int p = 0; p < 3; p++) begin
      press = 4'b0010;
      tick();
      press = '0;
      tick();
    end
    check("merge_pending", int'(dbg_pending), 2);
`ifdef BTN_DROP_COUNT_EN
    check("merge_drop_cnt", int'(drop_cnt), 2);
`endif
    key_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain5_code", int'(key_code), exp5[k]);
      tick();
    end
    check("drain5_empty", int'(key_valid), 0);

    // arb_en hold
    arb_en = 1'b0;
    press = 4'b0011;
    tick();
    press = '0;
    for (int k = 0; k < 3; k++) begin
      check("hold_no_valid", int'(key_valid), 0);
      tick();
    end
    check("hold_pending", int'(dbg_pending), 3);
    arb_en = 1'b1;
    tick();
    check("rel_code0", int'(key_code), 0);
    check("rel_valid0", int'(key_valid), 1);
    tick();
    check("rel_code1", int'(key_code), 1);
    check("rel_valid1", int'(key_valid), 1);
    tick();
    check("rel_empty", int'(key_valid), 0);

    // reset mid-queue
    key_ready = 1'b0;
    press = 4'b0111;
    tick();
    press = '0;
    ticks(3);
    check("pre_rst_count", int'(fifo_count), 3);
    reset = 1'b1;
    #1;
    check("async_rst_valid", int'(key_valid), 0);
    check("async_rst_count", int'(fifo_count), 0);
    ticks(2);
    reset = 1'b0;
    tick();
    check("post_rst_pending", int'(dbg_pending), 0);
    check("post_rst_rr", int'(dbg_rr_ptr), 0);
`ifdef BTN_DROP_COUNT_EN
    check("post_rst_drop", int'(drop_cnt), 0);
`endif

    // mixed table, checked by the model each cycle
    for (int t = 0; t < 12; t++) begin
      press = tbl_press[t];
      key_ready = tbl_ready[t];
      arb_en = tbl_arb[t];
      tick();
    end
    press = '0;
    arb_en = 1'b1;
    key_ready = 1'b1;
    ticks(12);
    check("final_empty", int'(key_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
